trigger_window_scheduler: RTL and testbench

Round-robin scheduler that shares one signal-expansion window generator between CH_NUM trigger channels. Each channel's rising edge is latched as a pending request. Pending requests are granted one at a time. Each grant drives SIG_OUT high for EXTEND_LEN cycles, tagged with the granted channel ID, followed by a programmable hold-off. The block sits between the per-channel discriminator outputs and the downstream readout window logic. It replaces one independent expander per channel.

---
 rtl/trigger_window_scheduler_if.sv | 27 ++
 rtl/trigger_window_scheduler.sv | 124 ++++++++++++
 tb/tb_trigger_window_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_window_scheduler_if.sv
// Bus between the trigger discriminators, the shared window scheduler and the readout window logic.
// The master drives trigger levels and window settings; the slave returns the window and its bookkeeping.
interface trigger_window_scheduler_if #(
  parameter int unsigned CH_NUM               = 4,
  parameter int unsigned MAX_EXTEND_LEN_WIDTH = 5,
  parameter int unsigned HOLDOFF_LEN_WIDTH    = 3,
  parameter int unsigned ID_WIDTH             = $clog2(CH_NUM)
);
  logic [MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN;
  logic [HOLDOFF_LEN_WIDTH-1:0]    HOLDOFF_LEN;
  logic [CH_NUM-1:0]               SIG_IN;
  logic                            SIG_OUT;
  logic                            GRANT_VALID;
  logic [ID_WIDTH-1:0]             GRANT_ID;
  logic [CH_NUM-1:0]               PENDING;
  logic [CH_NUM-1:0]               DROP;

  modport master (
    output EXTEND_LEN, HOLDOFF_LEN, SIG_IN,
    input  SIG_OUT, GRANT_VALID, GRANT_ID, PENDING, DROP
  );

  modport slave (
    input  EXTEND_LEN, HOLDOFF_LEN, SIG_IN,
    output SIG_OUT, GRANT_VALID, GRANT_ID, PENDING, DROP
  );
endinterface

// File: rtl/trigger_window_scheduler.sv
// Round-robin scheduler sharing one window expander between CH_NUM trigger channels.
// Rising edges are latched as pending requests and granted one window at a time.
module trigger_window_scheduler #(
  parameter int unsigned CH_NUM               = 4,
  parameter int unsigned MAX_EXTEND_LEN_WIDTH = 5,
  parameter int unsigned HOLDOFF_LEN_WIDTH    = 3,
  parameter int unsigned ID_WIDTH             = $clog2(CH_NUM)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  trigger_window_scheduler_if.slave   if_bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [ID_WIDTH-1:0] LP_LAST_GRANT_RST = ID_WIDTH'(CH_NUM - 1);

  state_t                          r_state;
  logic [MAX_EXTEND_LEN_WIDTH-1:0] r_cnt;
  logic [HOLDOFF_LEN_WIDTH-1:0]    r_hcnt;
  logic [CH_NUM-1:0]               r_sig_d;
  logic [CH_NUM-1:0]               r_pending;
  logic [CH_NUM-1:0]               r_drop;
  logic [ID_WIDTH-1:0]             r_last_grant;
  logic [ID_WIDTH-1:0]             r_grant_id;
  logic                            r_sig_out;

  logic [CH_NUM-1:0]               w_rise;
  logic [CH_NUM-1:0]               w_grant_mask;
  logic [ID_WIDTH-1:0]             w_winner;
  logic [ID_WIDTH-1:0]             w_idx;
  logic                            w_grant;
  logic [MAX_EXTEND_LEN_WIDTH-1:0] w_ext_len;

  assign w_rise    = if_bus.SIG_IN & ~r_sig_d;
  assign w_grant   = (r_state == ST_IDLE) && (|r_pending);
  assign w_ext_len = (if_bus.EXTEND_LEN == '0) ? MAX_EXTEND_LEN_WIDTH'(1) : if_bus.EXTEND_LEN;

  // Scan from the farthest offset down so the nearest pending channel after last_grant wins.
  always_comb begin : arbiter
    w_winner = '0;
    w_idx    = '0;
    for (int off = int'(CH_NUM); off >= 1; off--) begin
      w_idx = ID_WIDTH'((int'(r_last_grant) + off) % int'(CH_NUM));
      if (r_pending[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_grant_mask = w_grant ? (CH_NUM'(1) << w_winner) : '0;

  // A grant and a fresh rise on the same channel in one cycle re-queues it without a drop.
  always_ff @(posedge CLK or posedge RESET) begin : pending_ff
    if (RESET) begin
      r_sig_d   <= '0;
      r_pending <= '0;
      r_drop    <= '0;
    end else begin
      r_sig_d   <= if_bus.SIG_IN;
      r_pending <= (r_pending & ~w_grant_mask) | w_rise;
      r_drop    <= w_rise & r_pending & ~w_grant_mask;
    end
  end

  // Window FSM; settings are captured on entry to each phase so later changes do not disturb it.
  always_ff @(posedge CLK or posedge RESET) begin : window_fsm
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_last_grant <= LP_LAST_GRANT_RST;
      r_grant_id   <= '0;
      r_sig_out    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state      <= ST_ACTIVE;
            r_cnt        <= w_ext_len;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_sig_out    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (r_cnt == MAX_EXTEND_LEN_WIDTH'(1)) begin
            r_sig_out <= 1'b0;
            if (if_bus.HOLDOFF_LEN != '0) begin
              r_state <= ST_HOLDOFF;
              r_hcnt  <= if_bus.HOLDOFF_LEN;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - MAX_EXTEND_LEN_WIDTH'(1);
          end
        end
        ST_HOLDOFF: begin
          if (r_hcnt == HOLDOFF_LEN_WIDTH'(1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_hcnt <= r_hcnt - HOLDOFF_LEN_WIDTH'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_sig_out <= 1'b0;
        end
      endcase
    end
  end

  assign if_bus.SIG_OUT     = r_sig_out;
  assign if_bus.GRANT_VALID = r_sig_out;
  assign if_bus.GRANT_ID    = r_grant_id;
  assign if_bus.PENDING     = r_pending;
  assign if_bus.DROP        = r_drop;

endmodule

// File: tb/tb_trigger_window_scheduler.sv
// Bench for trigger_window_scheduler: directed scenarios plus random traffic against a
// timeline model (grant edge, window end edge, earliest next grant edge).
module tb_trigger_window_scheduler;
  localparam int CH  = 4;
  localparam int EW  = 5;
  localparam int HW  = 3;
  localparam int IDW = 2;
  localparam int VW  = 2 + IDW + 2 * CH;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  trigger_window_scheduler_if #(
    .CH_NUM(CH), .MAX_EXTEND_LEN_WIDTH(EW), .HOLDOFF_LEN_WIDTH(HW), .ID_WIDTH(IDW)
  ) bus ();

  trigger_window_scheduler #(
    .CH_NUM(CH), .MAX_EXTEND_LEN_WIDTH(EW), .HOLDOFF_LEN_WIDTH(HW), .ID_WIDTH(IDW)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .if_bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Timeline reference model
  logic [CH-1:0]  m_pend, m_prev, m_drop;
  logic           m_out;
  logic [IDW-1:0] m_id;
  int             m_last, m_edge, m_next_grant, m_win_end;

  // Observed window summaries, nibble-packed behind a leading 1 marker
  longint unsigned e_ids, e_lens, e_gaps, e_pend;
  logic t_prev_out, t_have_fall;
  int   t_len, t_gap, t_first, t_cyc;

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_drop = '0; m_out = 1'b0; m_id = '0;
    m_last = CH - 1; m_edge = 0; m_next_grant = 0; m_win_end = 0;
  endtask

  task automatic model_edge(input logic [CH-1:0] sig, input int ext, input int hold);
    logic [CH-1:0] rise;
    int g, c;
    rise   = sig & ~m_prev;
    m_prev = sig;
    m_edge++;
    if (m_out && m_edge == m_win_end) begin
      m_out        = 1'b0;
      m_next_grant = m_edge + hold + 1;
    end
    g = -1;
    if (!m_out && m_edge >= m_next_grant && m_pend != '0) begin
      for (int k = 1; k <= CH; k++) begin
        c = (m_last + k) % CH;
        if (g < 0 && m_pend[c]) g = c;
      end
      m_last    = g;
      m_id      = IDW'(g);
      m_out     = 1'b1;
      m_win_end = m_edge + ((ext == 0) ? 1 : ext);
    end
    m_drop = '0;
    for (int i = 0; i < CH; i++) begin
      if (rise[i] && m_pend[i] && i != g) m_drop[i] = 1'b1;
      m_pend[i] = (m_pend[i] && i != g) || rise[i];
    end
  endtask

  task automatic track_clear();
    e_ids = 1; e_lens = 1; e_gaps = 1; e_pend = 1;
    t_prev_out = 1'b0; t_have_fall = 1'b0; t_len = 0; t_gap = 0; t_first = -1; t_cyc = 0;
  endtask

  task automatic track();
    if (bus.SIG_OUT && !t_prev_out) begin
      e_ids  = (e_ids << 4) | longint'(bus.GRANT_ID);
      e_pend = (e_pend << 4) | longint'(bus.PENDING);
      if (t_have_fall) e_gaps = (e_gaps << 4) | longint'(t_gap & 15);
      if (t_first < 0) t_first = t_cyc;
      t_len = 1;
    end else if (bus.SIG_OUT) begin
      t_len++;
    end else if (t_prev_out) begin
      e_lens = (e_lens << 4) | longint'(t_len & 15);
      t_gap = 1; t_have_fall = 1'b1;
    end else begin
      t_gap++;
    end
    t_prev_out = bus.SIG_OUT;
    t_cyc++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(bus.SIG_IN, int'(bus.EXTEND_LEN), int'(bus.HOLDOFF_LEN));
    #1;
    track();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    model_reset();
    track_clear();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.SIG_OUT, bus.GRANT_VALID, bus.GRANT_ID, bus.PENDING, bus.DROP};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_out, m_out, m_id, m_pend, m_drop};
  endfunction

  task automatic test_reset();
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd4; bus.HOLDOFF_LEN = 3'd0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if (dut_vec() !== '0) begin
      n_bad++; $display("FAIL reset_hold got=%h exp=%h", dut_vec(), {VW{1'b0}});
    end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_single();
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd10; bus.HOLDOFF_LEN = 3'd0;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      bus.SIG_IN = (c < 20) ? 4'b0001 : 4'b0000;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL single cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if (t_first != 1) begin n_bad++; $display("FAIL single_latency got=%0d exp=1", t_first); end
    n_total++;
    if (e_lens != 64'h1A) begin n_bad++; $display("FAIL single_len got=%h exp=1a", e_lens); end
    n_total++;
    if (e_ids != 64'h10) begin n_bad++; $display("FAIL single_ids got=%h exp=10", e_ids); end
  endtask

  task automatic test_simultaneous();
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd3; bus.HOLDOFF_LEN = 3'd2;
    do_reset();
    for (int c = 0; c < 35; c++) begin
      bus.SIG_IN = (c == 0) ? 4'b1111 : 4'b0000;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL simul cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if (e_ids != 64'h10123) begin n_bad++; $display("FAIL simul_order got=%h exp=10123", e_ids); end
    n_total++;
    if (e_lens != 64'h13333) begin n_bad++; $display("FAIL simul_lens got=%h exp=13333", e_lens); end
    n_total++;
    if (e_gaps != 64'h1333) begin n_bad++; $display("FAIL simul_gaps got=%h exp=1333", e_gaps); end
    n_total++;
    if (e_pend != 64'h1EC80) begin n_bad++; $display("FAIL simul_pending got=%h exp=1ec80", e_pend); end
  endtask

  task automatic test_round_robin();
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd4; bus.HOLDOFF_LEN = 3'd1;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      bus.SIG_IN = (c == 0) ? 4'b0100 : (c == 2) ? 4'b1001 : 4'b0000;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL rr cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if (e_ids != 64'h1230) begin n_bad++; $display("FAIL rr_order got=%h exp=1230", e_ids); end
  endtask

  task automatic test_drop_requeue();
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd8; bus.HOLDOFF_LEN = 3'd0;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      bus.SIG_IN = (c == 0) ? 4'b0001 : (c == 2 || c == 4) ? 4'b0010 : 4'b0000;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL drop cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
      if (c == 4) begin
        n_total++;
        if (bus.DROP !== 4'b0010) begin n_bad++; $display("FAIL drop_pulse got=%b exp=0010", bus.DROP); end
      end
    end
    n_total++;
    if (e_ids != 64'h101) begin n_bad++; $display("FAIL drop_ids got=%h exp=101", e_ids); end

    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd3; bus.HOLDOFF_LEN = 3'd0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.SIG_IN = (c == 0) ? 4'b0011 : (c == 5) ? 4'b0010 : 4'b0000;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL requeue cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
      if (c == 5) begin
        n_total++;
        if ({bus.PENDING[1], bus.DROP} !== 5'b1_0000 || bus.GRANT_ID !== 2'd1) begin
          n_bad++; $display("FAIL requeue_same_cycle got pend1=%b drop=%b id=%0d exp pend1=1 drop=0000 id=1",
                            bus.PENDING[1], bus.DROP, bus.GRANT_ID);
        end
      end
    end
    n_total++;
    if (e_ids != 64'h1011) begin n_bad++; $display("FAIL requeue_ids got=%h exp=1011", e_ids); end
  endtask

  task automatic test_extend_len();
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd0; bus.HOLDOFF_LEN = 3'd0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.SIG_IN = (c == 0) ? 4'b0001 : 4'b0000;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL ext0 cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if (e_lens != 64'h11) begin n_bad++; $display("FAIL ext0_len got=%h exp=11", e_lens); end

    bus.EXTEND_LEN = 5'd10;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.SIG_IN = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      if (c == 5) bus.EXTEND_LEN = 5'd2;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL extchg cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if (e_lens != 64'h1A2) begin n_bad++; $display("FAIL extchg_lens got=%h exp=1a2", e_lens); end
  endtask

  task automatic test_reset_mid();
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd10; bus.HOLDOFF_LEN = 3'd0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus.SIG_IN = (c == 0) ? 4'b0001 : (c == 2) ? 4'b0100 : 4'b0000;
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if ({bus.SIG_OUT, bus.PENDING} !== 5'b1_0100) begin
      n_bad++; $display("FAIL rstmid_setup got out=%b pend=%b exp out=1 pend=0100", bus.SIG_OUT, bus.PENDING);
    end
    bus.SIG_IN = 4'b1000;
    #2 RESET = 1'b1;
    #1;
    n_total++;
    if ({bus.SIG_OUT, bus.GRANT_VALID, bus.PENDING} !== 6'b0) begin
      n_bad++; $display("FAIL rstmid_async got out=%b gv=%b pend=%b exp 0 0 0000",
                        bus.SIG_OUT, bus.GRANT_VALID, bus.PENDING);
    end
    do_reset();
    for (int c = 0; c < 15; c++) begin
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if (e_ids != 64'h13) begin n_bad++; $display("FAIL rstmid_ids got=%h exp=13", e_ids); end
    bus.SIG_IN = '0;
  endtask

  task automatic test_random();
    logic [CH-1:0] s;
    bus.SIG_IN = '0; bus.EXTEND_LEN = 5'd2; bus.HOLDOFF_LEN = 3'd1;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s = bus.SIG_IN;
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 3) == 0) s[i] = ~s[i];
      bus.SIG_IN = s;
      if ($urandom_range(0, 7) == 0) bus.EXTEND_LEN = EW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) bus.HOLDOFF_LEN = HW'($urandom_range(0, 3));
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    bus.SIG_IN = '0;
    bus.EXTEND_LEN = '0;
    bus.HOLDOFF_LEN = '0;
    model_reset();
    track_clear();
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_drop_requeue();
    test_extend_len();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
